control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Clocking SHALL be one clock, Clock, with reset Reset, asynchronous and active-low.
REQ-002 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-low; forces RESET_ST.
REQ-004 IR  input  32  instruction register contents: opcode IR[31:27]; Ra, Rb, Rc fields are decoded by the datapath.
REQ-005 CON_FF  input  1  branch condition from the datapath CON logic.
REQ-006 Stop  input  1  halt request.
REQ-007 Interrupts  input  1  reserved; ignored.
REQ-008 PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout  output  1 each  bus-source enables.
REQ-009 MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin  output  1 each  register loads.
REQ-010 Gra, Grb, Grc, Rin, Rout  output  1 each  register-file select and direction.
REQ-011 IncPC, Read, Write, Clear  output  1 each  PC increment, memory read/write, datapath clear.
REQ-012 AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT  output  1 each  one-hot ALU op; all 0 means no op.
REQ-013 Run  output  1  high unless in RESET_ST or HALT.

Function
REQ-014 State SHALL be {RESET_ST, T0..T7, HALT}. Every output SHALL be a Moore function of the current state and latched IR only.
REQ-015 Opcodes SHALL be: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, br 10010, jr 10011, in 10101, out 10110, mfhi 10111, mflo 11000, nop 11001, halt 11010. Any other code SHALL execute as nop.
REQ-016 RESET_ST SHALL assert Clear only, then go to T0 on the next edge.
REQ-017 Fetch: T0 = PCout, MARin, IncPC, Zin; T1 = Zlowout, PCin, Read, MDRin; T2 = MDRout, IRin.
REQ-018 Three-register ALU ops (add through or): T3 = Grb, Rout, Yin; T4 = Grc, Rout, op, Zin; T5 = Zlowout, Gra, Rin. neg/not: T3 = Grb, Rout, op, Zin; T4 = Zlowout, Gra, Rin.
REQ-019 Immediate ops (addi, andi, ori; ldi uses ADD): T3 = Grb, BAout, Yin; T4 = Cout, op, Zin; T5 = Zlowout, Gra, Rin.
REQ-020 mul/div: T3 = Gra, Rout, Yin; T4 = Grb, Rout, op, Zin; T5 = Zlowout, LOin; T6 = Zhighout, HIin.
REQ-021 ld: T3 to T4 as ldi; T5 = Zlowout, MARin; T6 = Read, MDRin; T7 = MDRout, Gra, Rin.
REQ-022 st: T3 to T5 as ld; T6 = Gra, Rout, MDRin (Read low); T7 = Write.
REQ-023 br: T3 = Gra, Rout, CONin; T4 = PCout, Yin; T5 = Cout, ADD, Zin; T6 = Zlowout and PCin only if CON_FF=1, otherwise no outputs.
REQ-024 Single-step ops at T3: jr = Gra, Rout, PCin; in = InPortout, Gra, Rin; out = Gra, Rout, OutPortin; mfhi = HIout, Gra, Rin; mflo = LOout, Gra, Rin; nop = no outputs.
REQ-025 After an instruction's last step, the next state SHALL be T0, or HALT if Stop=1 at that edge. halt at T3 SHALL go to HALT.
REQ-026 HALT SHALL assert no outputs and hold until Reset. Stop asserted mid-instruction SHALL NOT abort the instruction.
REQ-027 At most one bus-source enable SHALL be high in any state.

Reset
REQ-028 Reset low SHALL asynchronously enter RESET_ST from any state, including mid-instruction and HALT. All outputs SHALL be 0 except Clear=1 while in RESET_ST.

Structure
REQ-029 Opcode constants and state encodings SHALL live in shared package cpu_pkg.
REQ-030 Opcode-to-instruction-class decode SHALL be sub-module instr_decode (combinational); the FSM SHALL be in control_unit.

Verification
REQ-031 Reset low then high: one cycle of Clear=1, Run=1 from T0, PCout/MARin/IncPC/Zin high at T0.
REQ-032 IR=0x18918000 (add R1,R2,R3): T3 Grb/Rout/Yin, T4 Grc/Rout/ADD/Zin, T5 Zlowout/Gra/Rin, T0 next; 6 cycles total.
REQ-033 ld: Read high exactly at T1 and T6, Gra/Rin at T7; st: Write high only at T7.
REQ-034 br with CON_FF=0 gives no PCin at T6; with CON_FF=1, Zlowout and PCin are high at T6.
REQ-035 mul with Stop raised at T4: HI/LO loads at T5/T6, then HALT with Run=0; halt opcode: HALT after T3.
REQ-036 Reset pulsed low during ld T5: immediate RESET_ST, Write/Read=0, restart at T0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode constants, FSM state encoding and control-word layout
// for the multi-cycle CPU control unit.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    // One-hot ALU op, MSB first: AND OR ADD SUB MUL DIV SHR SHL ROR ROL NEG NOT
    localparam logic [11:0] ALU_NONE = 12'h000;
    localparam logic [11:0] ALU_AND  = 12'h800;
    localparam logic [11:0] ALU_OR   = 12'h400;
    localparam logic [11:0] ALU_ADD  = 12'h200;
    localparam logic [11:0] ALU_SUB  = 12'h100;
    localparam logic [11:0] ALU_MUL  = 12'h080;
    localparam logic [11:0] ALU_DIV  = 12'h040;
    localparam logic [11:0] ALU_SHR  = 12'h020;
    localparam logic [11:0] ALU_SHL  = 12'h010;
    localparam logic [11:0] ALU_ROR  = 12'h008;
    localparam logic [11:0] ALU_ROL  = 12'h004;
    localparam logic [11:0] ALU_NEG  = 12'h002;
    localparam logic [11:0] ALU_NOT  = 12'h001;

    typedef enum logic [3:0] {
        RESET_ST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU3, C_UNARY, C_IMM, C_MULDIV, C_LD, C_ST, C_BR,
        C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } iclass_t;

    typedef struct packed {
        logic pc_out, zhigh_out, zlow_out, mdr_out, hi_out;
        logic lo_out, inport_out, c_out, ba_out;
        logic mar_in, z_in, pc_in, mdr_in, ir_in, y_in;
        logic hi_in, lo_in, outport_in, con_in;
        logic gra, grb, grc, r_in, r_out;
        logic inc_pc, read, write, clear;
        logic [11:0] alu;
        logic run;
    } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// Maps the 5-bit opcode to an instruction class and its ALU operation.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [4:0]  opcode,
    output iclass_t     cls,
    output logic [11:0] alu
);

    always_comb begin
        cls = C_NOP;
        alu = ALU_NONE;
        unique case (opcode)
            OP_LD:   begin cls = C_LD;     alu = ALU_ADD; end
            OP_LDI:  begin cls = C_IMM;    alu = ALU_ADD; end
            OP_ST:   begin cls = C_ST;     alu = ALU_ADD; end
            OP_ADD:  begin cls = C_ALU3;   alu = ALU_ADD; end
            OP_SUB:  begin cls = C_ALU3;   alu = ALU_SUB; end
            OP_SHR:  begin cls = C_ALU3;   alu = ALU_SHR; end
            OP_SHL:  begin cls = C_ALU3;   alu = ALU_SHL; end
            OP_ROR:  begin cls = C_ALU3;   alu = ALU_ROR; end
            OP_ROL:  begin cls = C_ALU3;   alu = ALU_ROL; end
            OP_AND:  begin cls = C_ALU3;   alu = ALU_AND; end
            OP_OR:   begin cls = C_ALU3;   alu = ALU_OR;  end
            OP_ADDI: begin cls = C_IMM;    alu = ALU_ADD; end
            OP_ANDI: begin cls = C_IMM;    alu = ALU_AND; end
            OP_ORI:  begin cls = C_IMM;    alu = ALU_OR;  end
            OP_MUL:  begin cls = C_MULDIV; alu = ALU_MUL; end
            OP_DIV:  begin cls = C_MULDIV; alu = ALU_DIV; end
            OP_NEG:  begin cls = C_UNARY;  alu = ALU_NEG; end
            OP_NOT:  begin cls = C_UNARY;  alu = ALU_NOT; end
            OP_BR:   cls = C_BR;
            OP_JR:   cls = C_JR;
            OP_IN:   cls = C_IN;
            OP_OUT:  cls = C_OUT;
            OP_MFHI: cls = C_MFHI;
            OP_MFLO: cls = C_MFLO;
            OP_HALT: cls = C_HALT;
            default: cls = C_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle Moore control FSM: fetch T0-T2, per-class execute T3-T7,
// HALT until reset.
module control_unit
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    input  logic        Interrupts,
    output logic PCout, Zhighout, Zlowout, MDRout, HIout,
    output logic LOout, InPortout, Cout, BAout,
    output logic MARin, Zin, PCin, MDRin, IRin, Yin,
    output logic HIin, LOin, OutPortin, CONin,
    output logic Gra, Grb, Grc, Rin, Rout,
    output logic IncPC, Read, Write, Clear,
    output logic AND, OR, ADD, SUB, MUL, DIV,
    output logic SHR, SHL, ROR, ROL, NEG, NOT,
    output logic Run
);

    state_t      state, nxt;
    iclass_t     cls;
    logic [11:0] alu;
    logic        last;
    ctrl_t       c;
    logic        unused_ok;

    assign unused_ok = ^{IR[26:0], Interrupts};

    instr_decode u_dec (
        .opcode (IR[31:27]),
        .cls    (cls),
        .alu    (alu)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= RESET_ST;
        else        state <= nxt;
    end

    always_comb begin
        nxt   = state;
        c     = '0;
        c.run = 1'b1;
        last  = 1'b0;
        unique case (state)
            RESET_ST: begin
                c.run = 1'b0; c.clear = 1'b1; nxt = T0;
            end
            T0: begin
                c.pc_out = 1'b1; c.mar_in = 1'b1;
                c.inc_pc = 1'b1; c.z_in = 1'b1; nxt = T1;
            end
            T1: begin
                c.zlow_out = 1'b1; c.pc_in = 1'b1;
                c.read = 1'b1; c.mdr_in = 1'b1; nxt = T2;
            end
            T2: begin
                c.mdr_out = 1'b1; c.ir_in = 1'b1; nxt = T3;
            end
            T3: begin
                nxt = T4;
                case (cls)
                    C_ALU3: begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
                    C_UNARY: begin
                        c.grb = 1'b1; c.r_out = 1'b1; c.alu = alu; c.z_in = 1'b1;
                    end
                    C_IMM, C_LD, C_ST: begin
                        c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
                    end
                    C_MULDIV: begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
                    C_BR:  begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
                    C_JR: begin
                        c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; last = 1'b1;
                    end
                    C_IN: begin
                        c.inport_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; last = 1'b1;
                    end
                    C_OUT: begin
                        c.gra = 1'b1; c.r_out = 1'b1; c.outport_in = 1'b1; last = 1'b1;
                    end
                    C_MFHI: begin
                        c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; last = 1'b1;
                    end
                    C_MFLO: begin
                        c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; last = 1'b1;
                    end
                    C_HALT:  nxt = HALT;
                    default: last = 1'b1;
                endcase
            end
            T4: begin
                nxt = T5;
                case (cls)
                    C_ALU3: begin
                        c.grc = 1'b1; c.r_out = 1'b1; c.alu = alu; c.z_in = 1'b1;
                    end
                    C_UNARY: begin
                        c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; last = 1'b1;
                    end
                    C_IMM, C_LD, C_ST: begin
                        c.c_out = 1'b1; c.alu = alu; c.z_in = 1'b1;
                    end
                    C_MULDIV: begin
                        c.grb = 1'b1; c.r_out = 1'b1; c.alu = alu; c.z_in = 1'b1;
                    end
                    C_BR:    begin c.pc_out = 1'b1; c.y_in = 1'b1; end
                    default: last = 1'b1;
                endcase
            end
            T5: begin
                nxt = T6;
                case (cls)
                    C_ALU3, C_IMM: begin
                        c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; last = 1'b1;
                    end
                    C_MULDIV:    begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
                    C_LD, C_ST:  begin c.zlow_out = 1'b1; c.mar_in = 1'b1; end
                    C_BR: begin
                        c.c_out = 1'b1; c.alu = ALU_ADD; c.z_in = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            T6: begin
                nxt = T7;
                case (cls)
                    C_MULDIV: begin
                        c.zhigh_out = 1'b1; c.hi_in = 1'b1; last = 1'b1;
                    end
                    C_LD: begin c.read = 1'b1; c.mdr_in = 1'b1; end
                    C_ST: begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; end
                    C_BR: begin
                        c.zlow_out = CON_FF; c.pc_in = CON_FF; last = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            T7: begin
                last = 1'b1;
                case (cls)
                    C_LD: begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                    C_ST:    c.write = 1'b1;
                    default: ;
                endcase
            end
            HALT: c.run = 1'b0;
            default: begin
                c.run = 1'b0; nxt = RESET_ST;
            end
        endcase
        // Stop is only honoured at an instruction boundary.
        if (last) nxt = Stop ? HALT : T0;
    end

    assign {PCout, Zhighout, Zlowout, MDRout, HIout,
            LOout, InPortout, Cout, BAout,
            MARin, Zin, PCin, MDRin, IRin, Yin,
            HIin, LOin, OutPortin, CONin,
            Gra, Grb, Grc, Rin, Rout,
            IncPC, Read, Write, Clear,
            AND, OR, ADD, SUB, MUL, DIV,
            SHR, SHL, ROR, ROL, NEG, NOT,
            Run} = c;

endmodule

// File: tb/tb_control_unit.sv
// Directed cycle-by-cycle check of every control output of control_unit
// against hand-written expected control words.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Reset, CON_FF, Stop, Interrupts;
    logic [31:0] IR;
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin;
    logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write, Clear;
    logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, Run;

    always #5 Clock = ~Clock;

    control_unit dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .CON_FF(CON_FF),
        .Stop(Stop), .Interrupts(Interrupts),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
        .InPortout(InPortout), .Cout(Cout), .BAout(BAout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
        .OutPortin(OutPortin), .CONin(CONin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .IncPC(IncPC), .Read(Read), .Write(Write), .Clear(Clear),
        .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
        .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
        .Run(Run)
    );

    logic [40:0] sig;
    assign sig = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout,
                  Cout, BAout, MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
                  OutPortin, CONin, Gra, Grb, Grc, Rin, Rout, IncPC, Read,
                  Write, Clear, AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR,
                  ROL, NEG, NOT, Run};

    localparam logic [40:0] ONE = 41'd1;
    localparam logic [40:0] B_PCOUT = ONE << 40, B_ZHI = ONE << 39;
    localparam logic [40:0] B_ZLO = ONE << 38, B_MDROUT = ONE << 37;
    localparam logic [40:0] B_HIOUT = ONE << 36, B_LOOUT = ONE << 35;
    localparam logic [40:0] B_INPOUT = ONE << 34, B_COUT = ONE << 33;
    localparam logic [40:0] B_BAOUT = ONE << 32, B_MARIN = ONE << 31;
    localparam logic [40:0] B_ZIN = ONE << 30, B_PCIN = ONE << 29;
    localparam logic [40:0] B_MDRIN = ONE << 28, B_IRIN = ONE << 27;
    localparam logic [40:0] B_YIN = ONE << 26, B_HIIN = ONE << 25;
    localparam logic [40:0] B_LOIN = ONE << 24, B_OUTPIN = ONE << 23;
    localparam logic [40:0] B_CONIN = ONE << 22, B_GRA = ONE << 21;
    localparam logic [40:0] B_GRB = ONE << 20, B_GRC = ONE << 19;
    localparam logic [40:0] B_RIN = ONE << 18, B_ROUT = ONE << 17;
    localparam logic [40:0] B_INCPC = ONE << 16, B_READ = ONE << 15;
    localparam logic [40:0] B_WRITE = ONE << 14, B_CLEAR = ONE << 13;
    localparam logic [40:0] B_ADD = ONE << 10, B_MUL = ONE << 8;
    localparam logic [40:0] B_NEG = ONE << 2, B_RUN = ONE;

    localparam logic [40:0] V_CLR  = B_CLEAR;
    localparam logic [40:0] V_HALT = '0;
    localparam logic [40:0] V_IDLE = B_RUN;
    localparam logic [40:0] F0 = B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [40:0] F1 = B_RUN | B_ZLO | B_PCIN | B_READ | B_MDRIN;
    localparam logic [40:0] F2 = B_RUN | B_MDROUT | B_IRIN;
    localparam logic [40:0] A3 = B_RUN | B_GRB | B_ROUT | B_YIN;
    localparam logic [40:0] A4 = B_RUN | B_GRC | B_ROUT | B_ADD | B_ZIN;
    localparam logic [40:0] WB = B_RUN | B_ZLO | B_GRA | B_RIN;
    localparam logic [40:0] L3 = B_RUN | B_GRB | B_BAOUT | B_YIN;
    localparam logic [40:0] L4 = B_RUN | B_COUT | B_ADD | B_ZIN;
    localparam logic [40:0] L5 = B_RUN | B_ZLO | B_MARIN;
    localparam logic [40:0] L6 = B_RUN | B_READ | B_MDRIN;
    localparam logic [40:0] L7 = B_RUN | B_MDROUT | B_GRA | B_RIN;
    localparam logic [40:0] S6 = B_RUN | B_GRA | B_ROUT | B_MDRIN;
    localparam logic [40:0] S7 = B_RUN | B_WRITE;
    localparam logic [40:0] BR3 = B_RUN | B_GRA | B_ROUT | B_CONIN;
    localparam logic [40:0] BR4 = B_RUN | B_PCOUT | B_YIN;
    localparam logic [40:0] BR5 = B_RUN | B_COUT | B_ADD | B_ZIN;
    localparam logic [40:0] BR6T = B_RUN | B_ZLO | B_PCIN;
    localparam logic [40:0] M3 = B_RUN | B_GRA | B_ROUT | B_YIN;
    localparam logic [40:0] M4 = B_RUN | B_GRB | B_ROUT | B_MUL | B_ZIN;
    localparam logic [40:0] M5 = B_RUN | B_ZLO | B_LOIN;
    localparam logic [40:0] M6 = B_RUN | B_ZHI | B_HIIN;
    localparam logic [40:0] N3 = B_RUN | B_GRB | B_ROUT | B_NEG | B_ZIN;
    localparam logic [40:0] IN3 = B_RUN | B_INPOUT | B_GRA | B_RIN;

    int passed = 0;
    int total  = 0;
    logic [40:0] q[$];

    task automatic check(input string tag, input logic [40:0] got,
                         input logic [40:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Check the current cycle against each queued word, advancing one clock per word.
    task automatic play(input string tag);
        for (int i = 0; i < q.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), sig, q[i]);
            tick();
        end
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b0;
        #1;
        check({tag, "_clr"}, sig, V_CLR);
        @(negedge Clock);
        Reset = 1'b1;
        tick();
        check({tag, "_t0"}, sig, F0);
    endtask

    initial begin
        Reset = 1'b0; IR = '0; CON_FF = 1'b0; Stop = 1'b0; Interrupts = 1'b0;
        #12;
        check("reset_held", sig, V_CLR);
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        check("reset_released", sig, V_CLR);
        tick();

        IR = 32'h18918000;
        q = '{F0, F1, F2, A3, A4, WB};
        play("add");

        IR = 32'h00800000;
        q = '{F0, F1, F2, L3, L4, L5, L6, L7};
        play("ld");

        IR = 32'h10000000;
        q = '{F0, F1, F2, L3, L4, L5, S6, S7};
        play("st");

        IR = 32'h90000000; CON_FF = 1'b0;
        q = '{F0, F1, F2, BR3, BR4, BR5, V_IDLE};
        play("br_nt");

        CON_FF = 1'b1;
        q = '{F0, F1, F2, BR3, BR4, BR5, BR6T};
        play("br_t");
        CON_FF = 1'b0;

        IR = 32'h80000000;
        q = '{F0, F1, F2, N3, WB};
        play("neg");

        IR = 32'hA8000000;
        q = '{F0, F1, F2, IN3};
        play("in");

        IR = 32'hF8000000;
        q = '{F0, F1, F2, V_IDLE};
        play("undef_nop");

        IR = 32'h70000000;
        q = '{F0, F1, F2, M3};
        play("mul_a");
        Stop = 1'b1;
        q = '{M4, M5, M6};
        play("mul_b");
        check("mul_halt", sig, V_HALT);
        tick();
        Stop = 1'b0;
        tick();
        check("halt_hold", sig, V_HALT);
        do_reset("rst_halt");

        IR = 32'hD0000000;
        q = '{F0, F1, F2, V_IDLE};
        play("halt_op");
        check("halt_op_st", sig, V_HALT);
        tick();
        check("halt_op_hold", sig, V_HALT);
        do_reset("rst_hop");

        IR = 32'h00800000;
        q = '{F0, F1, F2, L3, L4};
        play("ld_mid");
        check("ld_mid[5]", sig, L5);
        #2;
        do_reset("rst_mid");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
